// File: rtl/instr_fetch_decode_if.sv
// Bundle between the fetch/decode stage, instruction memory and the
// downstream pipeline. The fetch/decode block takes the master side.
interface instr_fetch_decode_if;
  logic [7:0]  PC;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        ready;
  logic        valid;
  logic        pc_en;
  logic [15:0] IR;
  logic        PL;
  logic        JB;
  logic        BC;
  logic        MB;
  logic        MD;
  logic        RW;
  logic        MW;
  logic [5:0]  AD;
  logic [2:0]  DA;
  logic [2:0]  AA;
  logic [2:0]  BA;
  logic [3:0]  FS;
  logic        fault;

  modport master (
    input  PC, imem_ack, imem_data, ready,
    output imem_req, imem_addr, valid, pc_en, IR,
           PL, JB, BC, MB, MD, RW, MW, AD, DA, AA, BA, FS, fault
  );

  modport slave (
    output PC, imem_ack, imem_data, ready,
    input  imem_req, imem_addr, valid, pc_en, IR,
           PL, JB, BC, MB, MD, RW, MW, AD, DA, AA, BA, FS, fault
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch with timeout fault, instruction register and
// combinational decode of the held instruction.
module instr_fetch_decode #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_decode_if.master  bus
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ADDR  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 req_q, req_d;
  logic                 valid_q, valid_d;
  logic                 fault_q, fault_d;
  logic                 pl_raw;

  // Next-state logic; an ack on the threshold cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    case (state_q)
      ADDR: begin
        addr_d  = bus.PC;
        cnt_d   = '0;
        state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (bus.ready) state_d = ADDR;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = ADDR;
      end
    endcase
    req_d   = (state_d == FETCH);
    valid_d = (state_d == HOLD);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ADDR;
      addr_q  <= '0;
      cnt_q   <= '0;
      ir_q    <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.valid     = valid_q;
  assign bus.fault     = fault_q;
  assign bus.pc_en     = valid_q & bus.ready;
  assign bus.IR        = ir_q;

  // Decode; side-effecting controls are suppressed unless an instruction is presented.
  assign pl_raw  = ir_q[14] & ir_q[15];
  assign bus.PL  = pl_raw & valid_q;
  assign bus.MW  = ir_q[14] & ~ir_q[15] & valid_q;
  assign bus.RW  = ~ir_q[14] & valid_q;
  assign bus.MB  = ir_q[15];
  assign bus.MD  = ir_q[13];
  assign bus.JB  = ir_q[13];
  assign bus.BC  = ir_q[9];
  assign bus.DA  = ir_q[8:6];
  assign bus.AA  = ir_q[5:3];
  assign bus.BA  = ir_q[2:0];
  assign bus.AD  = {ir_q[8:6], ir_q[2:0]};
  assign bus.FS  = {ir_q[12:10], ir_q[9] & ~pl_raw};

endmodule
